// File: rtl/siso_shift_reg.sv
// Serial-in/serial-out shift register.
// A DEPTH-stage bit chain that advances by one stage on every clock edge where
// shift is high. Use it as a fixed-length bit delay line or as a serial buffer.
// Stage 0 is the input end. Stage DEPTH-1 drives serial_out.
//
// Control semantics:
//   - There is no valid/ready handshake.
//   - shift is a plain enable, sampled only on posedge clk.
//   - serial_in is sampled on the same edge, and only when shift=1.
//   - reset is asynchronous and active-high. It overrides shift.
//   - serial_out is taken straight from a flop, so no input reaches it
//     combinationally.
module siso_shift_reg #(
  parameter int unsigned            DEPTH       = 4,
  parameter logic [DEPTH-1:0]       RESET_VALUE = {DEPTH{1'b0}}
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  input  logic shift,
  output logic serial_out
);

  logic [DEPTH-1:0] stage;
  logic [DEPTH-1:0] stage_next;

  // Next chain value on an enabled edge: new bit enters at stage 0, oldest bit drops off.
  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        stage_next = serial_in;
      end
    end else begin : g_chain
      always_comb begin
        stage_next = {stage[DEPTH-2:0], serial_in};
      end
    end
  endgenerate

  // Chain register: async reset to RESET_VALUE, advance only when shift is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= RESET_VALUE;
    end else if (shift) begin
      stage <= stage_next;
    end
  end

  assign serial_out = stage[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_reg.sv
// Directed self-checking bench for siso_shift_reg.
// Three instances are driven: DEPTH=4 (default), DEPTH=1, and DEPTH=8 with
// RESET_VALUE=8'h80. Each has its own shift/serial_in. Reset is shared.
// Outputs are sampled 1ns after the rising edge, and inputs change there too.
module tb_siso_shift_reg;

  logic clk;
  logic reset;

  logic sin4, shift4, out4;
  logic sin1, shift1, out1;
  logic sin8, shift8, out8;

  int n_assert;
  int n_fail;

  logic [11:0] pat_in;
  logic [11:0] pat_exp;

  siso_shift_reg #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .serial_in(sin4), .shift(shift4), .serial_out(out4)
  );

  siso_shift_reg #(.DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .serial_in(sin1), .shift(shift1), .serial_out(out1)
  );

  siso_shift_reg #(.DEPTH(8), .RESET_VALUE(8'h80)) dut8 (
    .clk(clk), .reset(reset), .serial_in(sin8), .shift(shift8), .serial_out(out8)
  );

  // Clock: 10ns period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reset pulse placed between clock edges; caller is 1ns after a posedge.
  task automatic reset_pulse();
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // ---------------- reset held with shift=1, serial_in=1 ----------------
    reset  = 1'b1;
    sin4   = 1'b1; shift4 = 1'b1;
    sin1   = 1'b1; shift1 = 1'b1;
    sin8   = 1'b1; shift8 = 1'b1;
    #1;
    chk("rst_async_out4", out4, 1'b0);
    chk("rst_async_out1", out1, 1'b0);
    chk("rst_async_out8", out8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_out4", out4, 1'b0);
      chk("rst_hold_out1", out1, 1'b0);
      chk("rst_hold_out8", out8, 1'b1);
    end
    shift4 = 1'b0; shift1 = 1'b0; shift8 = 1'b0;
    sin4   = 1'b0; sin1   = 1'b0; sin8   = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    chk("post_rst_out4", out4, 1'b0);
    chk("post_rst_out8", out8, 1'b1);

    // Flushing zeros shows every stage of dut4 came out of reset at 0.
    shift4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_flush4", out4, 1'b0);
    end

    // ---------------- single pulse through DEPTH=4 ----------------
    sin4 = 1'b1;
    tick();
    chk("pulse_e1", out4, 1'b0);
    sin4 = 1'b0;
    tick();
    chk("pulse_e2", out4, 1'b0);
    tick();
    chk("pulse_e3", out4, 1'b0);
    tick();
    chk("pulse_e4", out4, 1'b1);
    tick();
    chk("pulse_e5", out4, 1'b0);

    // ---------------- hold with shift=0 ----------------
    sin4 = 1'b1;
    tick();
    chk("hold_in1", out4, 1'b0);
    sin4 = 1'b0;
    tick();
    chk("hold_in0", out4, 1'b0);
    shift4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sin4 = i[0];
      tick();
      chk("hold_idle", out4, 1'b0);
    end
    shift4 = 1'b1;
    sin4   = 1'b0;
    tick();
    chk("hold_resume1", out4, 1'b0);
    tick();
    chk("hold_resume2", out4, 1'b1);

    // ---------------- continuous pattern ----------------
    reset_pulse();
    tick();
    chk("pat_after_rst", out4, 1'b0);
    // serial_in on edges 1..12 (MSB first), and serial_out after each edge:
    // the bit from edge j appears after edge j+3.
    pat_in  = 12'b1011_0010_0000;
    pat_exp = 12'b0001_0110_0100;
    shift4 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      sin4 = pat_in[11-j];
      tick();
      chk("pattern", out4, pat_exp[11-j]);
    end

    // ---------------- async reset mid-stream ----------------
    sin4 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_loaded", out4, 1'b1);
    shift4 = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_async4", out4, 1'b0);
    chk("mid_rst_async8", out8, 1'b1);
    #1;
    reset = 1'b0;
    shift4 = 1'b1;
    sin4   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_after", out4, 1'b0);
    end
    shift4 = 1'b0;

    // ---------------- DEPTH=1 ----------------
    shift1 = 1'b1;
    sin1 = 1'b1; tick(); chk("d1_a", out1, 1'b1);
    sin1 = 1'b0; tick(); chk("d1_b", out1, 1'b0);
    sin1 = 1'b1; tick(); chk("d1_c", out1, 1'b1);
    sin1 = 1'b1; tick(); chk("d1_d", out1, 1'b1);
    shift1 = 1'b0;
    sin1   = 1'b0;
    tick(); chk("d1_hold", out1, 1'b1);
    tick(); chk("d1_hold2", out1, 1'b1);

    // ---------------- DEPTH=8, RESET_VALUE=8'h80 ----------------
    reset_pulse();
    chk("d8_rst_val", out8, 1'b1);
    tick();
    chk("d8_after_rst", out8, 1'b1);
    // First enabled edge shifts the reset '1' out and a new '1' in.
    shift8 = 1'b1;
    sin8   = 1'b1;
    tick();
    chk("d8_e1", out8, 1'b0);
    sin8 = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("d8_mid", out8, 1'b0);
    end
    // A disabled edge in the middle does not count toward the delay.
    shift8 = 1'b0;
    tick();
    chk("d8_gap", out8, 1'b0);
    shift8 = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      tick();
      chk("d8_mid", out8, 1'b0);
    end
    tick();
    chk("d8_e8", out8, 1'b1);
    tick();
    chk("d8_e9", out8, 1'b0);
    shift8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
